// File: rtl/program_counter.sv
// Program counter for a single-cycle ARM-style datapath. Each cycle it selects
// PC+4, a PC-relative branch target or an absolute register target.

module full_adder (
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [63:0] sum
);
   // Two's-complement wrap: the carry-out is dropped.
   assign sum = a + b;
endmodule

module mux2to1 (
   input  logic        sel,
   input  logic [63:0] in0,
   input  logic [63:0] in1,
   output logic [63:0] out
);
   assign out = sel ? in1 : in0;
endmodule

module resettable_generator (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [63:0] d,
   output logic [63:0] q
);
   // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         q <= '0;
      else if (en)
         q <= d;
   end
endmodule

module program_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        UncondBr,
   input  logic        BrTaken,
   input  logic        BranchToReg,
   input  logic [25:0] BrAddr26,
   input  logic [18:0] CondAddr19,
   input  logic [63:0] RegAddress,
   output logic [63:0] PC,
   output logic [63:0] PCPlusFour
);
   logic [63:0] off19;
   logic [63:0] off26;
   logic [63:0] off;
   logic [63:0] off_bytes;
   logic [63:0] rel_target;
   logic [63:0] br_addr;
   logic [63:0] next_pc;

   assign off19 = {{45{CondAddr19[18]}}, CondAddr19};
   assign off26 = {{38{BrAddr26[25]}}, BrAddr26};

   mux2to1 u_off_mux (
      .sel (UncondBr),
      .in0 (off19),
      .in1 (off26),
      .out (off)
   );

   // Offsets count instructions; shifting by two turns them into bytes.
   assign off_bytes = off << 2;

   full_adder u_plus_four (
      .a   (PC),
      .b   (64'd4),
      .sum (PCPlusFour)
   );

   full_adder u_rel_adder (
      .a   (PC),
      .b   (off_bytes),
      .sum (rel_target)
   );

   mux2to1 u_target_mux (
      .sel (BranchToReg),
      .in0 (rel_target),
      .in1 (RegAddress),
      .out (br_addr)
   );

   mux2to1 u_next_mux (
      .sel (BrTaken),
      .in0 (PCPlusFour),
      .in1 (br_addr),
      .out (next_pc)
   );

   // No stall input exists, so the PC register loads every cycle.
   resettable_generator u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .d     (next_pc),
      .q     (PC)
   );
endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed test-plan sequence plus
// randomized control/offset stimulus against an arithmetic reference model.

module tb_program_counter;
   logic        clk;
   logic        reset;
   logic        UncondBr;
   logic        BrTaken;
   logic        BranchToReg;
   logic [25:0] BrAddr26;
   logic [18:0] CondAddr19;
   logic [63:0] RegAddress;
   logic [63:0] PC;
   logic [63:0] PCPlusFour;

   int          checks;
   int          errors;
   logic [63:0] model_pc;

   program_counter dut (
      .clk         (clk),
      .reset       (reset),
      .UncondBr    (UncondBr),
      .BrTaken     (BrTaken),
      .BranchToReg (BranchToReg),
      .BrAddr26    (BrAddr26),
      .CondAddr19  (CondAddr19),
      .RegAddress  (RegAddress),
      .PC          (PC),
      .PCPlusFour  (PCPlusFour)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%016h expected=0x%016h", tag, got, exp);
      end
   endtask

   // Reference next-PC from the architectural rules, using signed integers.
   function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic unc,
                                            input logic taken, input logic to_reg,
                                            input logic [25:0] b26, input logic [18:0] c19,
                                            input logic [63:0] ra);
      longint offset;
      if (!taken) return pc + 64'd4;
      if (to_reg) return ra;
      offset = unc ? longint'($signed(b26)) : longint'($signed(c19));
      return pc + 64'(offset * 4);
   endfunction

   // One clock edge: predict, clock, then compare 1 time unit later.
   task automatic step(input string tag);
      model_pc = ref_next(model_pc, UncondBr, BrTaken, BranchToReg,
                          BrAddr26, CondAddr19, RegAddress);
      @(posedge clk);
      #1;
      check({tag, "_pc"}, PC, model_pc);
      check({tag, "_pc4"}, PCPlusFour, model_pc + 64'd4);
   endtask

   task automatic set_ctl(input logic taken, input logic to_reg, input logic unc);
      BrTaken     = taken;
      BranchToReg = to_reg;
      UncondBr    = unc;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b0;
      set_ctl(1'b0, 1'b0, 1'b0);
      BrAddr26    = 26'h3FFFFF8;
      CondAddr19  = 19'd12;
      RegAddress  = 64'd6;
      model_pc    = '0;

      // Reset held low across edges.
      repeat (2) @(posedge clk);
      #1;
      check("reset_pc", PC, 64'd0);
      check("reset_pc4", PCPlusFour, 64'd4);
      reset = 1'b1;

      for (int i = 1; i <= 10; i++) begin
         step("seq");
         check("seq_const", PC, 64'(4 * i));
      end

      set_ctl(1'b0, 1'b1, 1'b0);
      repeat (2) step("nt_reg");
      set_ctl(1'b0, 1'b0, 1'b1);
      repeat (4) step("nt_unc");
      check("nt_const", PC, 64'd64);

      set_ctl(1'b1, 1'b0, 1'b0);
      step("cond");
      check("cond_const1", PC, 64'd112);
      step("cond");
      check("cond_const2", PC, 64'd160);

      set_ctl(1'b1, 1'b1, 1'b0);
      repeat (2) step("regbr");
      check("regbr_const", PC, 64'd6);
      check("regbr_pc4", PCPlusFour, 64'd10);

      set_ctl(1'b1, 1'b0, 1'b1);
      step("back");
      check("back_const1", PC, 64'hFFFF_FFFF_FFFF_FFE6);
      step("back");
      check("back_const2", PC, 64'hFFFF_FFFF_FFFF_FFC6);
      set_ctl(1'b1, 1'b1, 1'b1);
      step("back_reg");
      check("back_reg_const", PC, 64'd6);

      // Wrap-around from the top of the address space.
      RegAddress = 64'hFFFF_FFFF_FFFF_FFFC;
      set_ctl(1'b1, 1'b1, 1'b0);
      step("wrap_load");
      check("wrap_pc4", PCPlusFour, 64'd0);
      set_ctl(1'b0, 1'b0, 1'b0);
      step("wrap");
      check("wrap_const", PC, 64'd0);

      // Randomized controls and offsets.
      for (int i = 0; i < 300; i++) begin
         BrTaken     = 1'($urandom_range(0, 1));
         BranchToReg = 1'($urandom_range(0, 1));
         UncondBr    = 1'($urandom_range(0, 1));
         BrAddr26    = 26'($urandom);
         CondAddr19  = 19'($urandom);
         RegAddress  = {$urandom, $urandom};
         step("rand");
      end

      // Asynchronous reset between edges with a nonzero PC.
      set_ctl(1'b1, 1'b1, 1'b0);
      RegAddress = 64'h0000_1234_5678_9AB0;
      step("pre_async");
      #2;
      reset = 1'b0;
      #1;
      check("async_pc", PC, 64'd0);
      check("async_pc4", PCPlusFour, 64'd4);
      @(posedge clk);
      #1;
      check("async_hold", PC, 64'd0);
      model_pc = '0;
      set_ctl(1'b0, 1'b1, 1'b1);
      reset = 1'b1;
      step("release");
      check("release_const", PC, 64'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
